ram: RTL

Synchronous single-port data RAM: the load/store counterpart to the instruction ROM, which only ever reads. It serves byte, halfword and word accesses from the core's load/store unit through a request/acknowledge handshake. Stores use an internal read-modify-write sequence. Loads return zero- or sign-extended data.

---
 rtl/ram.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ram.sv
// Single-port data RAM serving byte/half/word loads and stores via req/ack.
// Optional misaligned-access error response: define RAM_MISALIGN_ERR_EN.
module ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  hb_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned DW = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_MERGE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW+1:0] addr_q;
  logic [1:0]    hb_q;
  logic          we_q;
  logic          sign_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] buf_q;
  logic          ready_q, ready_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          capture_c;
  logic          misalign_c;
  logic [AW-1:0] idx_c;
  logic [DW-1:0] rd_word_c;
  logic          unused_c;

  logic [DW-1:0] mem_q [DEPTH];

  assign idx_c     = addr_q[AW+1:2];
  assign rd_word_c = mem_q[idx_c];
  // Address bits above the word index wrap and are deliberately dropped.
  assign unused_c  = ^addr_i[31:AW+2];

`ifdef RAM_MISALIGN_ERR_EN
  assign misalign_c = ((hb_i == 2'b01) && addr_i[0]) ||
                      (hb_i[1] && (addr_i[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Select the addressed lane of a word and zero/sign extend it.
  function automatic logic [DW-1:0] extract(input logic [DW-1:0] w, input logic [1:0] a,
                                            input logic [1:0] hb, input logic s);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (hb)
      2'b00:   extract = {{24{s & b[7]}}, b};
      2'b01:   extract = {{16{s & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Overlay the right-aligned store data onto the fetched word.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] w, input logic [1:0] a,
                                          input logic [1:0] hb, input logic [DW-1:0] d);
    logic [DW-1:0] m;
    m = w;
    case (hb)
      2'b00: begin
        case (a)
          2'd0:    m[7:0]   = d[7:0];
          2'd1:    m[15:8]  = d[7:0];
          2'd2:    m[23:16] = d[7:0];
          default: m[31:24] = d[7:0];
        endcase
      end
      2'b01: begin
        if (a[1]) m[31:16] = d[15:0];
        else      m[15:0]  = d[15:0];
      end
      default: m = d;
    endcase
    merge = m;
  endfunction

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    ack_d     = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          capture_c = 1'b1;
          if (misalign_c) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (we_q) begin
          state_d = S_MERGE;
        end else begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          rdata_d = extract(rd_word_c, addr_q[1:0], hb_q, sign_q);
        end
      end
      S_MERGE: begin
        state_d = S_RESP;
        ack_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hb_q    <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      wdata_q <= '0;
      buf_q   <= '0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (capture_c) begin
        addr_q  <= addr_i[AW+1:0];
        hb_q    <= hb_i;
        we_q    <= we_i;
        sign_q  <= sign_i;
        wdata_q <= wdata_i;
      end
      if (state_q == S_FETCH) buf_q <= rd_word_c;
    end
  end

  // Storage is never reset; a reset during MERGE suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == S_MERGE)) begin
      mem_q[idx_c] <= merge(buf_q, addr_q[1:0], hb_q, wdata_q);
    end
  end

  assign ready_o = ready_q;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
`ifdef RAM_MISALIGN_ERR_EN
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif

endmodule
